// File: rtl/rdc_seq_pkg.sv
// Shared types and constants for the reset-domain-crossing reset sequencer.
package rdc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISOLATE = 2'd1,
    ASSERT  = 2'd2,
    RELEASE = 2'd3
  } rdc_seq_state_t;

  localparam int SEQ_CNT_W = 8;

endpackage

// File: rtl/rdc_seq_timer.sv
// Loadable down-counter that times each sequencer phase; zero_o flags expiry.
module rdc_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/rdc_reset_sequencer.sv
// Destination-domain sequencer: isolate capture, pulse the source reset, settle, release.
// Optional RDC_SEQ_STATUS_EN adds a saturating completed-sequence counter on seq_cnt_o.
module rdc_reset_sequencer
  import rdc_seq_pkg::*;
#(
  parameter int QUIESCE_CYC = 4,
  parameter int HOLD_CYC    = 8,
  parameter int SETTLE_CYC  = 2,
  parameter int CNT_W       = 8
) (
  input  logic clk_b,
  input  logic rst_b,
  input  logic req_i,
  output logic iso_en_o,
  output logic src_rst_n_o,
  output logic busy_o,
  output logic done_o
`ifdef RDC_SEQ_STATUS_EN
  ,
  output logic [SEQ_CNT_W-1:0] seq_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] QUIESCE_LD = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);

  rdc_seq_state_t state_q, state_d;

  logic             req_q;
  logic             req_rise_q;
  logic             tmr_load;
  logic             tmr_dec;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  logic iso_q, iso_d;
  logic src_rst_n_q, src_rst_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  rdc_seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i      (clk_b),
    .rst_i      (rst_b),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_rise_q) begin
          tmr_load = 1'b1;
          tmr_val  = QUIESCE_LD;
          state_d  = ISOLATE;
        end
      end
      ISOLATE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
          state_d  = ASSERT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ASSERT: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
          state_d  = RELEASE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RELEASE: begin
        if (tmr_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register glitch-free.
  always_comb begin
    iso_d       = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    src_rst_n_d = (state_d != ASSERT);
  end

  // A rise is only captured while the FSM is idle, so edges seen during a
  // sequence (including its final RELEASE cycle) are dropped rather than queued.
  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      req_q       <= 1'b1;
      req_rise_q  <= 1'b0;
      state_q     <= IDLE;
      iso_q       <= 1'b0;
      src_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      req_q       <= req_i;
      req_rise_q  <= req_i & ~req_q & (state_q == IDLE);
      state_q     <= state_d;
      iso_q       <= iso_d;
      src_rst_n_q <= src_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign iso_en_o    = iso_q;
  assign src_rst_n_o = src_rst_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef RDC_SEQ_STATUS_EN
  logic [SEQ_CNT_W-1:0] seq_cnt_q;

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      seq_cnt_q <= '0;
    end else if (done_d && (seq_cnt_q != '1)) begin
      seq_cnt_q <= seq_cnt_q + 1'b1;
    end
  end

  assign seq_cnt_o = seq_cnt_q;
`endif

endmodule

// File: tb/tb_rdc_reset_sequencer.sv
// Directed-vector bench for rdc_reset_sequencer with a cycle-by-cycle expected queue.
module tb_rdc_reset_sequencer;

  localparam int Q = 4;
  localparam int H = 8;
  localparam int S = 2;
  localparam int NMAX = 80;
  localparam logic [3:0] IDLE_OUT = 4'b0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;
  logic req_i;
  logic iso_en_o;
  logic src_rst_n_o;
  logic busy_o;
  logic done_o;
`ifdef RDC_SEQ_STATUS_EN
  logic [7:0] seq_cnt_o;
  logic       rst1, req1, iso1, srcn1, busy1, done1;
  logic [7:0] seq_cnt1;
`endif

  rdc_reset_sequencer #(
    .QUIESCE_CYC(Q), .HOLD_CYC(H), .SETTLE_CYC(S), .CNT_W(8)
  ) u_dut (
    .clk_b       (clk),
    .rst_b       (rst_b),
    .req_i       (req_i),
    .iso_en_o    (iso_en_o),
    .src_rst_n_o (src_rst_n_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef RDC_SEQ_STATUS_EN
    ,
    .seq_cnt_o   (seq_cnt_o)
`endif
  );

`ifdef RDC_SEQ_STATUS_EN
  rdc_reset_sequencer #(
    .QUIESCE_CYC(1), .HOLD_CYC(1), .SETTLE_CYC(1), .CNT_W(8)
  ) u_dut_fast (
    .clk_b       (clk),
    .rst_b       (rst1),
    .req_i       (req1),
    .iso_en_o    (iso1),
    .src_rst_n_o (srcn1),
    .busy_o      (busy1),
    .done_o      (done1),
    .seq_cnt_o   (seq_cnt1)
  );
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: expected {iso_en, src_rst_n, busy, done} per cycle.
  logic [3:0] exp_q[$];
  int         cyc_q[$];
  string      cur_name;

  logic [3:0] exp_v[0:NMAX-1];
  logic       req_v[0:NMAX-1];
  logic       rst_v[0:NMAX-1];
  int         exp_done;

  logic [3:0] mon_e;
  logic [3:0] mon_got;
  int         mon_c;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_c   = cyc_q.pop_front();
      mon_got = {iso_en_o, src_rst_n_o, busy_o, done_o};
      n_cmp++;
      if (mon_got !== mon_e) begin
        n_bad++;
        $display("FAIL %s cycle %0d {iso,src_n,busy,done}: got %b expected %b",
                 cur_name, mon_c, mon_got, mon_e);
      end
    end
  end

  task automatic clear_vec();
    for (int c = 0; c < NMAX; c++) begin
      exp_v[c] = IDLE_OUT;
      req_v[c] = 1'b0;
      rst_v[c] = (c < 2);
    end
    exp_done = 0;
  endtask

  task automatic set_req(input int a, input int b, input logic v);
    for (int c = a; c <= b; c++) req_v[c] = v;
  endtask

  // Expected windows for a request rise sampled at edge t; cycles >= cut are
  // left idle (reset or end of the run).
  task automatic add_seq(input int t, input int cut);
    for (int c = t + 1; c <= t + Q + H + S; c++) begin
      if (c < cut) begin
        exp_v[c][3] = 1'b1;
        exp_v[c][1] = 1'b1;
      end
    end
    for (int c = t + 1 + Q; c <= t + Q + H; c++) begin
      if (c < cut) exp_v[c][2] = 1'b0;
    end
    if (t + 1 + Q + H + S < cut) begin
      exp_v[t + 1 + Q + H + S][0] = 1'b1;
      exp_done++;
    end
  endtask

  task automatic run(input string name, input int n);
    cur_name = name;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rst_b = rst_v[c];
      req_i = req_v[c];
      exp_q.push_back(exp_v[c]);
      cyc_q.push_back(c);
    end
    @(posedge clk);
    #2;
`ifdef RDC_SEQ_STATUS_EN
    n_cmp++;
    if (seq_cnt_o !== 8'(exp_done)) begin
      n_bad++;
      $display("FAIL %s seq_cnt: got %0d expected %0d", name, seq_cnt_o, exp_done);
    end
`endif
  endtask

  initial begin
    rst_b = 1'b1;
    req_i = 1'b0;
`ifdef RDC_SEQ_STATUS_EN
    rst1 = 1'b1;
    req1 = 1'b0;
`endif

    clear_vec();
    set_req(10, 30, 1'b1);
    add_seq(10, 32);
    run("basic", 32);

    clear_vec();
    set_req(10, 34, 1'b1);
    req_v[13] = 1'b0; req_v[17] = 1'b0; req_v[21] = 1'b0;
    add_seq(10, 35);
    run("busy_ignore", 35);

    clear_vec();
    set_req(10, 40, 1'b1);
    set_req(43, 62, 1'b1);
    add_seq(10, 63);
    add_seq(43, 63);
    run("held_request", 63);

    clear_vec();
    set_req(10, 39, 1'b1);
    rst_v[19] = 1'b1;
    add_seq(10, 19);
    run("reset_mid", 40);

    clear_vec();
    for (int c = 0; c < 6; c++) rst_v[c] = 1'b1;
    set_req(0, 20, 1'b1);
    set_req(22, 39, 1'b1);
    add_seq(22, 40);
    run("reset_req_held", 40);

    clear_vec();
    set_req(10, 23, 1'b1);
    set_req(25, 26, 1'b1);
    set_req(28, 45, 1'b1);
    add_seq(10, 46);
    add_seq(28, 46);
    run("rise_at_release_exit", 46);

    clear_vec();
    set_req(10, 19, 1'b1);
    set_req(30, 39, 1'b1);
    set_req(50, 59, 1'b1);
    add_seq(10, 70);
    add_seq(30, 70);
    add_seq(50, 70);
    run("three_seq", 70);

`ifdef RDC_SEQ_STATUS_EN
    cur_name = "saturate";
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      req1 = 1'b1;
      repeat (3) @(negedge clk);
      req1 = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (seq_cnt1 !== 8'd255) begin
      n_bad++;
      $display("FAIL saturate seq_cnt: got %0d expected 255", seq_cnt1);
    end
`endif

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
